// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer.
// Walks two NUM_WORDS*WORD_SIZE operands through the word-wide addsub stage,
// least-significant word first, one word per clock, chaining the carry.
// Optional feature macro: ADDSUB_SEQ_OVF_EN adds a registered two's-complement
// overflow output for the full-width operation.
//
// Handshake: start is looked at only in IDLE; the edge that sees start=1 there
// latches a_in/b_in/sub, after which those inputs may change freely. busy is
// high for exactly NUM_WORDS cycles, then done pulses for one cycle. start
// during RUN or DONE is dropped, never queued.

// Word-wide adder/subtractor. With sub=1 the carry-in is forced to 1 and y is
// inverted (x - y). With sub=0 the carry-in is cin when carry=1, else 0.
module addsub #(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  input  logic                 sub,
  input  logic                 carry,
  input  logic                 cin,
  output logic [WORD_SIZE-1:0] sum,
  output logic                 cout
);

  logic [WORD_SIZE-1:0] y_eff;
  logic                 c_eff;

  // Conditional inversion of y and carry-in selection, then the word add
  always_comb begin
    y_eff = sub ? ~y : y;
    c_eff = sub ? 1'b1 : (carry ? cin : 1'b0);
    {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{WORD_SIZE{1'b0}}, c_eff};
  end

endmodule

module mp_addsub_seq #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           sub,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] a_in,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] b_in,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_WORDS*WORD_SIZE-1:0] result,
  output logic                           carry_out,
  output logic                           zero,
  output logic [1:0]                     state_dbg
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic                           overflow
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int TW    = NUM_WORDS * WORD_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic                 carry_reg;
  logic                 op_sub;
  logic [TW-1:0]        a_reg;
  logic [TW-1:0]        b_reg;
  logic [TW-1:0]        result_reg;

  logic [WORD_SIZE-1:0] x_word;
  logic [WORD_SIZE-1:0] b_word;
  logic [WORD_SIZE-1:0] y_word;
  logic                 as_sub;
  logic                 as_carry;
  logic [WORD_SIZE-1:0] as_sum;
  logic                 as_cout;

  // Select the current operand words and set up addsub for this step. The
  // first word uses addsub's own subtract mode (inverted y, cin=1); later
  // words invert y here and chain carry_reg, since addsub would otherwise
  // force the carry-in to 1.
  always_comb begin
    x_word = '0;
    b_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        x_word = a_reg[i*WORD_SIZE +: WORD_SIZE];
        b_word = b_reg[i*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (idx == '0) begin
      as_sub   = op_sub;
      as_carry = 1'b0;
      y_word   = b_word;
    end else begin
      as_sub   = 1'b0;
      as_carry = 1'b1;
      y_word   = op_sub ? ~b_word : b_word;
    end
  end

  addsub #(.WORD_SIZE(WORD_SIZE)) u_addsub (
    .x     (x_word),
    .y     (y_word),
    .sub   (as_sub),
    .carry (as_carry),
    .cin   (carry_reg),
    .sum   (as_sum),
    .cout  (as_cout)
  );

  // Sequencer: accept in IDLE, one word per cycle in RUN, one-cycle DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      carry_reg  <= 1'b0;
      op_sub     <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_out  <= 1'b0;
      zero       <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            op_sub    <= sub;
            idx       <= '0;
            carry_reg <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
              result_reg[i*WORD_SIZE +: WORD_SIZE] <= as_sum;
            end
          end
          carry_reg <= as_cout;
          if (idx == LAST_IDX) begin
            // Lower words were all written earlier in this operation
            carry_out <= as_cout;
            zero      <= (result_reg[(NUM_WORDS-1)*WORD_SIZE-1:0] == '0) &&
                         (as_sum == '0);
`ifdef ADDSUB_SEQ_OVF_EN
            overflow  <= (x_word[WORD_SIZE-1] == y_word[WORD_SIZE-1]) &&
                         (as_sum[WORD_SIZE-1] != x_word[WORD_SIZE-1]);
`endif
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign result    = result_reg;
  assign state_dbg = state;

endmodule
